// File: rtl/intt_ctrl_if.sv
// Control/status bundle between the INTT scheduler and its datapath or bench.
// The scheduler side is the master modport; the requester/datapath side is the slave modport.
`timescale 1ns/1ps

interface intt_ctrl_if #(
  parameter int N        = 256,
  parameter int PARALLEL = 8
);
  localparam int LOGN = $clog2(N);
  localparam int CW   = $clog2(N);
  localparam int BW   = $clog2(N / 2);

  // Handshake: start is a level request sampled only in IDLE (no ready; busy
  // acknowledges it). A run completes when done=1, and done stays high until
  // start is dropped. hold stalls progress and suppresses every lane enable
  // for the cycles in which it is high.
  logic                start;
  logic                hold;
  logic                busy;
  logic                done;
  logic [LOGN-1:0]     stage;
  logic [CW-1:0]       cycle;
  logic [BW-1:0]       butterfly;
  logic [PARALLEL-1:0] lane_valid;
  logic                scale_active;
  logic [CW-1:0]       coeff_base;
  logic [PARALLEL-1:0] coeff_valid;

  modport master (
    input  start, hold,
    output busy, done, stage, cycle, butterfly, lane_valid,
           scale_active, coeff_base, coeff_valid
  );

  modport slave (
    output start, hold,
    input  busy, done, stage, cycle, butterfly, lane_valid,
           scale_active, coeff_base, coeff_valid
  );
endinterface

// File: rtl/intt_control_parallel.sv
// Inverse-NTT scheduler: walks Gentleman-Sande stages LOGN-1..0 issuing PARALLEL
// butterflies per cycle, then an optional N^-1 scaling pass over all coefficients.
`timescale 1ns/1ps

module intt_control_parallel #(
  parameter int N        = 256,
  parameter int PARALLEL = 8,
  parameter int DO_SCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  intt_ctrl_if.master  bus,
  output logic [1:0]   o_dbg_state
);
  localparam int LOGN = $clog2(N);
  localparam int CW   = $clog2(N);
  localparam int BW   = $clog2(N / 2);
  localparam int CPS  = (N / 2) / PARALLEL;
  localparam int SCL  = N / PARALLEL;

  localparam logic [CW-1:0]   CPS_LAST  = CW'(CPS - 1);
  localparam logic [CW-1:0]   SCL_LAST  = CW'(SCL - 1);
  localparam logic [LOGN-1:0] STAGE_TOP = LOGN'(LOGN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_SCALE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  logic [LOGN-1:0]     r_stage;
  logic [CW-1:0]       r_cycle;

  logic                w_compute;
  logic                w_scale;
  logic [BW-1:0]       w_butterfly;
  logic [CW-1:0]       w_coeff_base;
  logic [PARALLEL-1:0] w_lane_valid;
  logic [PARALLEL-1:0] w_coeff_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_stage <= STAGE_TOP;
      r_cycle <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_COMPUTE;
            r_stage <= STAGE_TOP;
            r_cycle <= '0;
          end
        end
        S_COMPUTE: begin
          if (!bus.hold) begin
            if (r_cycle != CPS_LAST) begin
              r_cycle <= r_cycle + CW'(1);
            end else begin
              r_cycle <= '0;
              if (r_stage != '0) begin
                r_stage <= r_stage - LOGN'(1);
              end else begin
                r_state <= (DO_SCALE != 0) ? S_SCALE : S_DONE;
              end
            end
          end
        end
        S_SCALE: begin
          if (!bus.hold) begin
            if (r_cycle != SCL_LAST) begin
              r_cycle <= r_cycle + CW'(1);
            end else begin
              r_cycle <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // done is held while the requester keeps start high
          if (!bus.start) begin
            r_state <= S_IDLE;
            r_stage <= STAGE_TOP;
            r_cycle <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_stage <= STAGE_TOP;
          r_cycle <= '0;
        end
      endcase
    end
  end

  assign w_compute    = (r_state == S_COMPUTE);
  assign w_scale      = (r_state == S_SCALE);
  assign w_butterfly  = w_compute ? BW'(int'(r_cycle) * PARALLEL) : '0;
  assign w_coeff_base = w_scale   ? CW'(int'(r_cycle) * PARALLEL) : '0;

  always_comb begin
    w_lane_valid  = '0;
    w_coeff_valid = '0;
    for (int l = 0; l < PARALLEL; l++) begin
      w_lane_valid[l]  = w_compute && !bus.hold && ((int'(w_butterfly) + l) < (N / 2));
      w_coeff_valid[l] = w_scale && !bus.hold && ((int'(w_coeff_base) + l) < N);
    end
  end

  assign bus.busy         = w_compute || w_scale;
  assign bus.done         = (r_state == S_DONE);
  assign bus.stage        = r_stage;
  assign bus.cycle        = r_cycle;
  assign bus.butterfly    = w_butterfly;
  assign bus.lane_valid   = w_lane_valid;
  assign bus.scale_active = w_scale;
  assign bus.coeff_base   = w_coeff_base;
  assign bus.coeff_valid  = w_coeff_valid;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_intt_control_parallel.sv
// Directed bench for the INTT scheduler: full runs, hold, held start, start toggling,
// async reset mid-scale, and a small N=16 / DO_SCALE=0 instance.
`timescale 1ns/1ps

module tb_intt_control_parallel;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg;
  logic [1:0] dbg16;
  int         checks = 0;
  int         errors = 0;
  int         busy_total = 0;
  int         busy16_total = 0;
  bit         scl16_seen = 1'b0;

  intt_ctrl_if #(.N(256), .PARALLEL(8)) bus ();
  intt_ctrl_if #(.N(16),  .PARALLEL(8)) bus16 ();

  intt_control_parallel #(.N(256), .PARALLEL(8), .DO_SCALE(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.master), .o_dbg_state(dbg)
  );

  intt_control_parallel #(.N(16), .PARALLEL(8), .DO_SCALE(0)) u_dut16 (
    .clk(clk), .rst(rst), .bus(bus16.master), .o_dbg_state(dbg16)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.busy)           busy_total   <= busy_total + 1;
    if (bus16.busy)         busy16_total <= busy16_total + 1;
    if (bus16.scale_active) scl16_seen   <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_compute(input int s, input int c, input bit held);
    chk("c_busy",  32'(bus.busy), 32'd1);
    chk("c_state", 32'(dbg), 32'd1);
    chk("c_stage", 32'(bus.stage), 32'(s));
    chk("c_cycle", 32'(bus.cycle), 32'(c));
    chk("c_bfly",  32'(bus.butterfly), 32'(c * 8));
    chk("c_lanes", 32'(bus.lane_valid), held ? 32'h00 : 32'hFF);
    chk("c_scl",   32'(bus.scale_active), 32'd0);
    chk("c_cvld",  32'(bus.coeff_valid), 32'd0);
  endtask

  task automatic check_scale(input int k);
    chk("s_busy",  32'(bus.busy), 32'd1);
    chk("s_state", 32'(dbg), 32'd2);
    chk("s_stage", 32'(bus.stage), 32'd0);
    chk("s_act",   32'(bus.scale_active), 32'd1);
    chk("s_base",  32'(bus.coeff_base), 32'(k * 8));
    chk("s_cvld",  32'(bus.coeff_valid), 32'hFF);
    chk("s_bfly",  32'(bus.butterfly), 32'd0);
    chk("s_lanes", 32'(bus.lane_valid), 32'd0);
  endtask

  // start pattern while running: 0 pulse, 1 held high, 2 toggling
  function automatic logic start_val(input int mode, input int idx);
    if (mode == 1) return 1'b1;
    if (mode == 2) return idx[0];
    return 1'b0;
  endfunction

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_full(input int mode, input int hs, input int hc, input int hl);
    int b0;
    bus.hold  = 1'b0;
    bus.start = 1'b1;
    b0 = busy_total;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    for (int s = 7; s >= 0; s--) begin
      for (int c = 0; c < 16; c++) begin
        if (s == hs && c == hc) begin
          for (int h = 0; h < hl; h++) begin
            bus.hold  = 1'b1;
            bus.start = start_val(mode, c + h);
            @(negedge clk);
            check_compute(s, c, 1'b1);
            @(posedge clk); #1;
          end
        end
        bus.hold  = 1'b0;
        bus.start = start_val(mode, c);
        @(negedge clk);
        check_compute(s, c, 1'b0);
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < 32; k++) begin
      bus.start = start_val(mode, k);
      @(negedge clk);
      check_scale(k);
      @(posedge clk); #1;
    end
    if (mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        bus.start = 1'b1;
        @(negedge clk);
        chk("done_held", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("done",       32'(bus.done), 32'd1);
    chk("done_state", 32'(dbg), 32'd3);
    chk("done_scl",   32'(bus.scale_active), 32'd0);
    @(posedge clk); #1;
    chk("back_done",  32'(bus.done), 32'd0);
    chk("back_busy",  32'(bus.busy), 32'd0);
    chk("back_stage", 32'(bus.stage), 32'd7);
    chk("back_cycle", 32'(bus.cycle), 32'd0);
    chk("back_state", 32'(dbg), 32'd0);
    chk("busy_len",   32'(busy_total - b0), 32'(160 + hl));
  endtask

  initial begin
    bit found;
    int b16;
    bus.start   = 1'b0;
    bus.hold    = 1'b0;
    bus16.start = 1'b0;
    bus16.hold  = 1'b0;

    // reset state
    #12;
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_stage", 32'(bus.stage), 32'd7);
    chk("rst_cycle", 32'(bus.cycle), 32'd0);
    chk("rst_lanes", 32'(bus.lane_valid), 32'd0);
    chk("rst_cvld",  32'(bus.coeff_valid), 32'd0);
    chk("rst_state", 32'(dbg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // pulse start, no hold
    run_full(0, -1, -1, 0);
    // 5-cycle hold at stage 3 / cycle 4
    run_full(0, 3, 4, 5);
    // start held through completion
    run_full(1, -1, -1, 0);
    // start toggling during the run
    run_full(2, -1, -1, 0);

    // async reset in the middle of the scaling pass
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (bus.scale_active && bus.coeff_base == 8'd64) found = 1'b1;
    end
    chk("mid_scale_reached", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy",  32'(bus.busy), 32'd0);
    chk("arst_done",  32'(bus.done), 32'd0);
    chk("arst_scl",   32'(bus.scale_active), 32'd0);
    chk("arst_cvld",  32'(bus.coeff_valid), 32'd0);
    chk("arst_stage", 32'(bus.stage), 32'd7);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_full(0, -1, -1, 0);

    // N=16, PARALLEL=8, no scaling: one cycle per stage
    b16 = busy16_total;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    for (int s = 3; s >= 0; s--) begin
      @(negedge clk);
      chk("n16_busy",  32'(bus16.busy), 32'd1);
      chk("n16_stage", 32'(bus16.stage), 32'(s));
      chk("n16_lanes", 32'(bus16.lane_valid), 32'hFF);
      chk("n16_bfly",  32'(bus16.butterfly), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("n16_done",  32'(bus16.done), 32'd1);
    chk("n16_state", 32'(dbg16), 32'd3);
    @(posedge clk); #1;
    chk("n16_idle_stage", 32'(bus16.stage), 32'd3);
    chk("n16_idle_done",  32'(bus16.done), 32'd0);
    chk("n16_busy_len",   32'(busy16_total - b16), 32'd4);
    chk("n16_no_scale",   32'(scl16_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
